vga_timing_monitor: RTL and testbench

//  Receive side of the VGA pixel interface: samples HS/VS/BLANK_n and 4-bit RGB from a

---
 rtl/vga_timing_monitor.sv | 232 +++++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// ---------------------------------------------------------------------------
// vga_timing_monitor
//
// Receive-side checker for a VGA-style pixel bus. It registers the incoming
// sync/blank/colour signals, recovers the coordinate of each active pixel,
// measures line and frame lengths, declares lock once enough consecutive
// frames match the nominal geometry, and grabs one probe pixel per frame.
//
// Ports
//   iVGA_CLK     pixel clock, all logic on its rising edge
//   iRST_n       asynchronous active-low reset
//   iHS, iVS     horizontal / vertical sync, active low
//   iBLANK_n     high during active pixels
//   iVGA_R/G/B   4-bit colour components
//   iProbeX/Y    coordinate of the pixel to capture (sampled live)
//   oActive      registered BLANK_n
//   oXPos/oYPos  coordinate of the pixel shown by oActive
//   oHTotal      clocks in the last completed line
//   oVTotal      lines in the last completed frame
//   oFrameDone   one-cycle pulse at each evaluated frame end
//   oTimingErr   pulse with oFrameDone when the frame did not match
//   oLocked      timing locked
//   oProbeRGB    last captured probe colour {R,G,B}
//   oProbeValid  pulse with oFrameDone when the probe was hit this frame
// ---------------------------------------------------------------------------
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [3:0]  iVGA_R,
    input  logic [3:0]  iVGA_G,
    input  logic [3:0]  iVGA_B,
    input  logic [10:0] iProbeX,
    input  logic [9:0]  iProbeY,
    output logic        oActive,
    output logic [10:0] oXPos,
    output logic [9:0]  oYPos,
    output logic [11:0] oHTotal,
    output logic [9:0]  oVTotal,
    output logic        oFrameDone,
    output logic        oTimingErr,
    output logic        oLocked,
    output logic [11:0] oProbeRGB,
    output logic        oProbeValid
);

    localparam logic [11:0] H_TOTAL_W  = 12'(H_TOTAL);
    localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
    localparam logic [9:0]  V_TOTAL_W  = 10'(V_TOTAL);
    localparam logic [9:0]  V_ACTIVE_W = 10'(V_ACTIVE);
    localparam logic [7:0]  LOCK_W     = 8'(LOCK_FRAMES);
    // hcnt value on the last clock of the two-line silence window
    localparam logic [11:0] WD_LAST    = 12'(2 * H_TOTAL - 1);

    typedef enum logic {
        WAIT_VS,
        MEASURE
    } frame_state_t;

    frame_state_t state, state_next;

    logic        hs_q, hs_prev, vs_q, vs_prev, blank_q;
    logic [11:0] rgb_q;
    logic [11:0] hcnt;
    logic        h_seen;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic [9:0]  line_cnt;
    logic        line_err;
    logic [7:0]  match_cnt;
    logic        hit;

    logic        hs_fall, vs_fall;
    logic [11:0] hcnt_inc;
    logic        line_active, line_bad, line_err_now;
    logic [9:0]  line_cnt_inc, y_cnt_inc;
    logic [9:0]  lines_closed, active_closed;
    logic        frame_bad, frame_eval, wd_expire;
    logic [7:0]  match_inc;
    logic        probe_hit;

    assign hs_fall = hs_prev & ~hs_q;
    assign vs_fall = vs_prev & ~vs_q;

    assign hcnt_inc     = (hcnt == 12'hFFF) ? hcnt : hcnt + 12'd1;
    assign line_cnt_inc = (line_cnt == 10'h3FF) ? line_cnt : line_cnt + 10'd1;
    assign y_cnt_inc    = (y_cnt == 10'h3FF) ? y_cnt : y_cnt + 10'd1;
    assign match_inc    = (match_cnt == 8'hFF) ? match_cnt : match_cnt + 8'd1;

    // Line closing at this HS fall: length and active-pixel count must match.
    // The very first HS fall after reset or loss has no reference, so it is
    // not judged.
    assign line_active  = (x_cnt != 11'd0);
    assign line_bad     = (hcnt_inc != H_TOTAL_W) || (line_active && (x_cnt != H_ACTIVE_W));
    assign line_err_now = hs_fall && h_seen && line_bad;

    // When HS and VS fall together the line is closed first, so the frame
    // totals below already include it.
    assign lines_closed  = hs_fall ? line_cnt_inc : line_cnt;
    assign active_closed = (hs_fall && line_active) ? y_cnt_inc : y_cnt;
    assign frame_bad     = (lines_closed != V_TOTAL_W) || (active_closed != V_ACTIVE_W)
                           || line_err || line_err_now;

    assign wd_expire = !hs_fall && (hcnt == WD_LAST);

    // Out-of-range probe coordinates are rejected explicitly because the
    // counters can run past the active area when the source misbehaves.
    assign probe_hit = blank_q && (x_cnt == iProbeX) && (y_cnt == iProbeY)
                       && (iProbeX < H_ACTIVE_W) && (iProbeY < V_ACTIVE_W);

    assign oActive = blank_q;
    assign oXPos   = x_cnt;
    assign oYPos   = y_cnt;

    // Frame tracker: a VS fall is only judged once a previous VS fall has
    // marked the frame start; the watchdog drops back to waiting.
    always_comb begin
        state_next = state;
        frame_eval = 1'b0;
        if (wd_expire) begin
            state_next = WAIT_VS;
        end else if (vs_fall) begin
            state_next = MEASURE;
            frame_eval = (state == MEASURE);
        end
    end

    // Input registers, counters, frame evaluation results and probe capture.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state       <= WAIT_VS;
            hs_q        <= 1'b0;
            hs_prev     <= 1'b0;
            vs_q        <= 1'b0;
            vs_prev     <= 1'b0;
            blank_q     <= 1'b0;
            rgb_q       <= 12'd0;
            hcnt        <= 12'd0;
            h_seen      <= 1'b0;
            x_cnt       <= 11'd0;
            y_cnt       <= 10'd0;
            line_cnt    <= 10'd0;
            line_err    <= 1'b0;
            match_cnt   <= 8'd0;
            hit         <= 1'b0;
            oHTotal     <= 12'd0;
            oVTotal     <= 10'd0;
            oFrameDone  <= 1'b0;
            oTimingErr  <= 1'b0;
            oLocked     <= 1'b0;
            oProbeRGB   <= 12'd0;
            oProbeValid <= 1'b0;
        end else begin
            state   <= state_next;
            hs_q    <= iHS;
            hs_prev <= hs_q;
            vs_q    <= iVS;
            vs_prev <= vs_q;
            blank_q <= iBLANK_n;
            rgb_q   <= {iVGA_R, iVGA_G, iVGA_B};

            if (hs_fall) begin
                hcnt   <= 12'd0;
                x_cnt  <= 11'd0;
                h_seen <= 1'b1;
                if (h_seen) begin
                    oHTotal <= hcnt_inc;
                end
            end else begin
                hcnt <= hcnt_inc;
                if (blank_q && (x_cnt != 11'h7FF)) begin
                    x_cnt <= x_cnt + 11'd1;
                end
            end
            if (wd_expire) begin
                h_seen <= 1'b0;
            end

            if (vs_fall) begin
                line_cnt <= 10'd0;
                y_cnt    <= 10'd0;
                line_err <= 1'b0;
            end else if (hs_fall) begin
                line_cnt <= line_cnt_inc;
                if (line_active) begin
                    y_cnt <= y_cnt_inc;
                end
                if (line_err_now) begin
                    line_err <= 1'b1;
                end
            end

            oFrameDone  <= frame_eval;
            oTimingErr  <= frame_eval && frame_bad;
            oProbeValid <= frame_eval && hit;
            if (frame_eval) begin
                oVTotal <= lines_closed;
            end

            if (wd_expire) begin
                match_cnt <= 8'd0;
                oLocked   <= 1'b0;
            end else if (frame_eval) begin
                if (frame_bad) begin
                    match_cnt <= 8'd0;
                    oLocked   <= 1'b0;
                end else begin
                    match_cnt <= match_inc;
                    if (match_inc >= LOCK_W) begin
                        oLocked <= 1'b1;
                    end
                end
            end

            if (vs_fall) begin
                hit <= 1'b0;
            end else if (probe_hit) begin
                hit       <= 1'b1;
                oProbeRGB <= rgb_q;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_monitor
//
// Drives a scaled-down VGA raster (40x20 clocks/lines, 24x12 active) into
// the monitor so that many frames fit in a short run. Pixel colours and
// probe coordinates are random; expectations come from the raster geometry
// the bench itself generates and a frame-level lock model.
// ---------------------------------------------------------------------------
module tb_vga_timing_monitor;

    localparam int H_TOT    = 40;
    localparam int H_ACT    = 24;
    localparam int V_TOT    = 20;
    localparam int V_ACT    = 12;
    localparam int LOCK_N   = 2;
    localparam int HS_START = 28;
    localparam int HS_LEN   = 6;
    localparam int VS_LINE  = 14;
    localparam int VS_LINES = 2;

    logic        iVGA_CLK = 1'b0;
    logic        iRST_n   = 1'b0;
    logic        iHS      = 1'b1;
    logic        iVS      = 1'b1;
    logic        iBLANK_n = 1'b0;
    logic [3:0]  iVGA_R   = 4'd0;
    logic [3:0]  iVGA_G   = 4'd0;
    logic [3:0]  iVGA_B   = 4'd0;
    logic [10:0] iProbeX  = 11'd0;
    logic [9:0]  iProbeY  = 10'd0;
    logic        oActive;
    logic [10:0] oXPos;
    logic [9:0]  oYPos;
    logic [11:0] oHTotal;
    logic [9:0]  oVTotal;
    logic        oFrameDone;
    logic        oTimingErr;
    logic        oLocked;
    logic [11:0] oProbeRGB;
    logic        oProbeValid;

    vga_timing_monitor #(
        .H_TOTAL     (H_TOT),
        .H_ACTIVE    (H_ACT),
        .V_TOTAL     (V_TOT),
        .V_ACTIVE    (V_ACT),
        .LOCK_FRAMES (LOCK_N)
    ) dut (
        .iVGA_CLK    (iVGA_CLK),
        .iRST_n      (iRST_n),
        .iHS         (iHS),
        .iVS         (iVS),
        .iBLANK_n    (iBLANK_n),
        .iVGA_R      (iVGA_R),
        .iVGA_G      (iVGA_G),
        .iVGA_B      (iVGA_B),
        .iProbeX     (iProbeX),
        .iProbeY     (iProbeY),
        .oActive     (oActive),
        .oXPos       (oXPos),
        .oYPos       (oYPos),
        .oHTotal     (oHTotal),
        .oVTotal     (oVTotal),
        .oFrameDone  (oFrameDone),
        .oTimingErr  (oTimingErr),
        .oLocked     (oLocked),
        .oProbeRGB   (oProbeRGB),
        .oProbeValid (oProbeValid)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    int vectors      = 0;
    int miscompares  = 0;
    int rec_count    = 0;
    int stray_pulses = 0;
    logic        rec_err    = 1'b0;
    logic        rec_locked = 1'b0;
    logic        rec_pv     = 1'b0;
    logic [9:0]  rec_vtotal = 10'd0;
    logic [11:0] rec_rgb    = 12'd0;

    // Frame-level reference: are we past a frame start, how many clean
    // frames in a row, lock state, and the colour last shown at the probe.
    bit          exp_measuring = 1'b0;
    int          exp_match     = 0;
    bit          exp_locked    = 1'b0;
    logic [11:0] exp_rgb       = 12'd0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock; results of the edge are sampled 1 ns later and any
    // frame-end pulse is latched for the frame-level checks.
    task automatic tick();
        @(posedge iVGA_CLK);
        #1;
        if (oFrameDone === 1'b1) begin
            rec_count++;
            rec_err    = oTimingErr;
            rec_locked = oLocked;
            rec_pv     = oProbeValid;
            rec_vtotal = oVTotal;
            rec_rgb    = oProbeRGB;
        end else if (oTimingErr !== 1'b0 || oProbeValid !== 1'b0) begin
            stray_pulses++;
        end
    endtask

    task automatic check_all_zero(input string when);
        check_output({when, "_active"},  {31'd0, oActive},     0);
        check_output({when, "_xpos"},    {21'd0, oXPos},       0);
        check_output({when, "_ypos"},    {22'd0, oYPos},       0);
        check_output({when, "_htotal"},  {20'd0, oHTotal},     0);
        check_output({when, "_vtotal"},  {22'd0, oVTotal},     0);
        check_output({when, "_done"},    {31'd0, oFrameDone},  0);
        check_output({when, "_err"},     {31'd0, oTimingErr},  0);
        check_output({when, "_locked"},  {31'd0, oLocked},     0);
        check_output({when, "_rgb"},     {20'd0, oProbeRGB},   0);
        check_output({when, "_pvalid"},  {31'd0, oProbeValid}, 0);
    endtask

    task automatic pick_probe(output int px, output int py);
        if ($urandom_range(0, 3) == 0) begin
            px = H_ACT + int'($urandom_range(0, 50));
        end else begin
            px = int'($urandom_range(0, H_ACT - 1));
        end
        py = int'($urandom_range(0, V_ACT - 1));
    endtask

    // One full raster frame. short_line >= 0 makes that line one clock short;
    // rst_line >= 0 pulses reset early in that line; zero_fill paints every
    // pixel black except F0A at the probe coordinate.
    task automatic apply_frame(input int short_line, input int rst_line,
                               input int px, input int py, input bit zero_fill);
        int          len;
        bit          active;
        bit          vs_low;
        logic [11:0] color;
        int          recs_before;
        int          stray_before;
        bit          frame_bad;
        bit          expect_hit;

        iProbeX      = 11'(px);
        iProbeY      = 10'(py);
        recs_before  = rec_count;
        stray_before = stray_pulses;

        for (int line = 0; line < V_TOT; line++) begin
            len = (line == short_line) ? H_TOT - 1 : H_TOT;
            for (int pos = 0; pos < len; pos++) begin
                if (line == rst_line && pos == 5) begin
                    iRST_n = 1'b0;
                    #1;
                    check_all_zero("mid_reset");
                    exp_measuring = 1'b0;
                    exp_match     = 0;
                    exp_locked    = 1'b0;
                    exp_rgb       = 12'd0;
                end
                if (line == rst_line && pos == 7) begin
                    iRST_n = 1'b1;
                end

                active = (line < V_ACT) && (pos < H_ACT);
                vs_low = ((line > VS_LINE) || (line == VS_LINE && pos >= HS_START)) &&
                         ((line < VS_LINE + VS_LINES) ||
                          (line == VS_LINE + VS_LINES && pos < HS_START));
                if (!active) begin
                    color = 12'd0;
                end else if (zero_fill) begin
                    color = (line == py && pos == px) ? 12'hF0A : 12'd0;
                end else begin
                    color = 12'($urandom);
                end

                iBLANK_n = active;
                iHS      = !(pos >= HS_START && pos < HS_START + HS_LEN);
                iVS      = !vs_low;
                {iVGA_R, iVGA_G, iVGA_B} = color;
                if (active && line == py && pos == px && iRST_n) begin
                    exp_rgb = color;
                end

                tick();

                if (!(rst_line >= 0 && line >= rst_line)) begin
                    if (active && ((line == 0 && pos == 0) ||
                                   (line == V_ACT - 1 && pos == H_ACT - 1) ||
                                   $urandom_range(0, 47) == 0)) begin
                        check_output("active_on", {31'd0, oActive}, 1);
                        check_output("xpos", {21'd0, oXPos}, pos);
                        check_output("ypos", {22'd0, oYPos}, line);
                    end else if (line < V_ACT && pos == H_ACT) begin
                        check_output("active_off", {31'd0, oActive}, 0);
                    end
                end
                if (short_line >= 0 && line == short_line + 1 && pos == HS_START + 4) begin
                    check_output("htotal_short", {20'd0, oHTotal}, H_TOT - 1);
                end
            end
        end

        check_output("stray_pulse", stray_pulses - stray_before, 0);
        check_output("htotal", {20'd0, oHTotal}, H_TOT);
        if (!exp_measuring) begin
            check_output("no_frame_done", rec_count - recs_before, 0);
            exp_measuring = 1'b1;
        end else begin
            frame_bad  = (short_line >= 0);
            expect_hit = (px < H_ACT) && (py < V_ACT);
            if (frame_bad) begin
                exp_match  = 0;
                exp_locked = 1'b0;
            end else begin
                exp_match++;
                if (exp_match >= LOCK_N) exp_locked = 1'b1;
            end
            check_output("frame_done_count", rec_count - recs_before, 1);
            check_output("timing_err", {31'd0, rec_err}, {31'd0, frame_bad});
            check_output("locked", {31'd0, rec_locked}, {31'd0, exp_locked});
            check_output("vtotal", {22'd0, rec_vtotal}, V_TOT);
            check_output("probe_valid", {31'd0, rec_pv}, {31'd0, expect_hit});
            check_output("probe_rgb", {20'd0, rec_rgb}, {20'd0, exp_rgb});
        end
    endtask

    // HS held inactive long enough for the loss-of-sync watchdog to fire.
    task automatic hold_hs(input int n);
        int recs_before;
        recs_before = rec_count;
        iHS      = 1'b1;
        iVS      = 1'b1;
        iBLANK_n = 1'b0;
        {iVGA_R, iVGA_G, iVGA_B} = 12'd0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == 40) begin
                check_output("locked_before_watchdog", {31'd0, oLocked}, {31'd0, exp_locked});
            end
        end
        check_output("locked_after_watchdog", {31'd0, oLocked}, 0);
        check_output("no_frame_done_in_hold", rec_count - recs_before, 0);
        exp_measuring = 1'b0;
        exp_match     = 0;
        exp_locked    = 1'b0;
    endtask

    initial begin
        int px;
        int py;

        $display("[TB] start");
        repeat (3) tick();
        check_all_zero("reset");
        iRST_n = 1'b1;

        // Nominal timing: first VS fall only arms, lock after two clean frames.
        for (int f = 0; f < 4; f++) begin
            pick_probe(px, py);
            apply_frame(-1, -1, px, py, 1'b0);
        end

        // One short line breaks lock; two clean frames restore it.
        pick_probe(px, py);
        apply_frame(5, -1, px, py, 1'b0);
        for (int f = 0; f < 2; f++) begin
            pick_probe(px, py);
            apply_frame(-1, -1, px, py, 1'b0);
        end

        // Lost HS: watchdog drops lock, next VS fall only re-arms.
        hold_hs(130);
        for (int f = 0; f < 3; f++) begin
            pick_probe(px, py);
            apply_frame(-1, -1, px, py, 1'b0);
        end

        // Directed probe cases: centre pixel, then X and Y out of range.
        apply_frame(-1, -1, H_ACT / 2, V_ACT / 2, 1'b1);
        apply_frame(-1, -1, H_ACT + 6, 3, 1'b0);
        apply_frame(-1, -1, 5, V_ACT + 3, 1'b0);

        // Reset in the middle of a locked frame.
        apply_frame(-1, 5, 2000, 1000, 1'b0);
        for (int f = 0; f < 5; f++) begin
            pick_probe(px, py);
            apply_frame(-1, -1, px, py, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
